// File: rtl/edc_encoder.sv
// EDC encoder: computes 8 check bits over a 32-bit word, buffers
// {data, check} in a 2-entry FIFO and can XOR a one-shot error mask
// into the next accepted word for corrector testing.
module edc_encoder #(
  parameter bit INJ_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [0:31] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [0:31] o_data,
  output logic [0:7]  o_check,
  input  logic        i_inj_arm,
  input  logic [0:39] i_inj_mask,
  output logic        o_inj_pending,
  output logic [15:0] o_count
);

  // Coverage masks, leftmost literal bit = data bit 0. Each data bit
  // appears in exactly three masks, giving weight-3 columns.
  localparam logic [0:31] M_C0 = 32'h8888_FF00;
  localparam logic [0:31] M_C1 = 32'h4444_00FF;
  localparam logic [0:31] M_C2 = 32'h2222_F0F0;
  localparam logic [0:31] M_C3 = 32'h1111_0F0F;
  localparam logic [0:31] M_C4 = 32'hFF00_8888;
  localparam logic [0:31] M_C5 = 32'h00FF_4444;
  localparam logic [0:31] M_C6 = 32'hF0F0_2222;
  localparam logic [0:31] M_C7 = 32'h0F0F_1111;

  logic [0:7]  w_check;
  logic        w_inXfer;
  logic        w_outXfer;
  logic [1:0]  w_cntNext;
  logic [0:39] w_word;
  logic        w_injApply;
  logic [0:39] w_injMask;

  logic [0:39] r_mem [0:1];
  logic        r_wrPtr;
  logic        r_rdPtr;
  logic [1:0]  r_cnt;
  logic        r_ready;
  logic [15:0] r_count;

  assign w_check = {^(i_data & M_C0), ^(i_data & M_C1),
                    ^(i_data & M_C2), ^(i_data & M_C3),
                    ^(i_data & M_C4), ^(i_data & M_C5),
                    ^(i_data & M_C6), ^(i_data & M_C7)};

  assign w_inXfer  = i_valid && r_ready;
  assign w_outXfer = (r_cnt != 2'd0) && i_ready;
  assign w_cntNext = r_cnt + {1'b0, w_inXfer} - {1'b0, w_outXfer};
  assign w_word    = {i_data, w_check} ^ (w_injApply ? w_injMask : 40'd0);

  generate
    if (INJ_EN) begin : g_inj
      logic        r_injPending;
      logic [0:39] r_injMask;

      // Arm latches only when idle; a pending mask is consumed by the next accepted word.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_injPending <= 1'b0;
          r_injMask    <= '0;
        end else if (r_injPending) begin
          if (w_inXfer) r_injPending <= 1'b0;
        end else if (i_inj_arm) begin
          r_injPending <= 1'b1;
          r_injMask    <= i_inj_mask;
        end
      end

      assign w_injApply    = r_injPending && w_inXfer;
      assign w_injMask     = r_injMask;
      assign o_inj_pending = r_injPending;
    end else begin : g_noInj
      logic w_unused;
      assign w_unused      = ^{i_inj_arm, i_inj_mask};
      assign w_injApply    = 1'b0;
      assign w_injMask     = '0;
      assign o_inj_pending = 1'b0;
    end
  endgenerate

  // FIFO storage, pointers, occupancy and the registered ready flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_cnt    <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_inXfer) begin
        r_mem[r_wrPtr] <= w_word;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_outXfer) r_rdPtr <= ~r_rdPtr;
      r_cnt   <= w_cntNext;
      r_ready <= (w_cntNext != 2'd2);
    end
  end

  // Emitted-word counter, wraps naturally at 16 bits.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_count <= 16'd0;
    else if (w_outXfer) r_count <= r_count + 16'd1;
  end

  assign o_ready = r_ready;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rdPtr][0:31];
  assign o_check = r_mem[r_rdPtr][32:39];
  assign o_count = r_count;

endmodule
